// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants, twiddle word layout and the fetch FSM encoding.
// Contents: FFT_N/LOG2N sizing, TW_W word width, real/imag field slices and
// helpers, and tw_fetch_state_t for the twiddle fetch engine.
package fft_pkg;

    localparam int unsigned LOG2N = 8;
    localparam int unsigned FFT_N = 1 << LOG2N;
    localparam int unsigned TW_W  = 64;

    // Twiddle word: float32 real in the upper half, float32 imaginary in the lower half
    localparam int unsigned TW_RE_MSB = 63;
    localparam int unsigned TW_RE_LSB = 32;
    localparam int unsigned TW_IM_MSB = 31;
    localparam int unsigned TW_IM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tw_fetch_state_t;

    function automatic logic [31:0] tw_re(input logic [TW_W-1:0] w);
        return w[TW_RE_MSB:TW_RE_LSB];
    endfunction

    function automatic logic [31:0] tw_im(input logic [TW_W-1:0] w);
        return w[TW_IM_MSB:TW_IM_LSB];
    endfunction

endpackage

// File: rtl/tw_skid_fifo.sv
// tw_skid_fifo: 2-entry FIFO with a registered head, carrying {data, index, last}.
// Ports: clk/rst (async active-high); wr_i + wr_data_i/wr_idx_i/wr_last_i push an
// entry; pop_i removes the head; occ_o is the occupancy (0..2) used for credit
// accounting; head_*_o present the oldest entry. Push and pop may coincide.
module tw_skid_fifo #(
    parameter int unsigned DW = 64,
    parameter int unsigned IW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [IW-1:0] wr_idx_i,
    input  logic          wr_last_i,
    input  logic          pop_i,
    output logic [1:0]    occ_o,
    output logic [DW-1:0] head_data_o,
    output logic [IW-1:0] head_idx_o,
    output logic          head_last_o
);

    localparam int unsigned EW = DW + IW + 1;

    logic [EW-1:0] head_q, head_d;
    logic [EW-1:0] tail_q, tail_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [EW-1:0] wr_entry;
    logic          pop_en;

    assign wr_entry = {wr_data_i, wr_idx_i, wr_last_i};
    assign pop_en   = pop_i && (cnt_q != 2'd0);

    // Next-state: the head register is always the oldest entry
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({wr_i, pop_en})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = wr_entry;
                else               tail_d = wr_entry;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = wr_entry;
                end else begin
                    head_d = wr_entry;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign occ_o       = cnt_q;
    assign head_data_o = head_q[EW-1:IW+1];
    assign head_idx_o  = head_q[IW:1];
    assign head_last_o = head_q[0];

endmodule

// File: rtl/twiddle_fetch.sv
// twiddle_fetch: walks the N/2 butterflies of one radix-2 DIF stage, reads the
// matching twiddle from a 1-cycle-latency ROM and streams it out valid/ready.
// Ports: clk/rst (async active-high); start/stage request a stage walk; busy/done
// report progress; rom_addr/rom_rd/rom_data form the ROM read port; tw_valid/
// tw_ready/tw_data/tw_idx/tw_last form the output stream.
module twiddle_fetch
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N = fft_pkg::LOG2N,
    parameter int unsigned DW    = fft_pkg::TW_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(LOG2N)-1:0] stage,
    output logic                     busy,
    output logic                     done,
    output logic [LOG2N-1:0]         rom_addr,
    output logic                     rom_rd,
    input  logic [DW-1:0]            rom_data,
    output logic                     tw_valid,
    input  logic                     tw_ready,
    output logic [DW-1:0]            tw_data,
    output logic [LOG2N-2:0]         tw_idx,
    output logic                     tw_last
);

    localparam int unsigned SW = $clog2(LOG2N);
    localparam int unsigned JW = LOG2N - 1;
    localparam int unsigned N  = 1 << LOG2N;
    localparam logic [JW-1:0] J_LAST = JW'(N / 2 - 1);

    tw_fetch_state_t state_q;
    logic [SW-1:0]   stage_q;
    logic [JW-1:0]   j_q;
    logic            inflight_q;
    logic [JW-1:0]   inflight_j_q;
    logic            inflight_last_q;

    logic [1:0]       occ;
    logic             pop;
    logic [2:0]       credit_used;
    logic [2:0]       credit_lim;
    logic [LOG2N-1:0] mask;

    // Entries already owned (FIFO + read in flight) must stay within the 2 slots
    assign pop         = tw_valid & tw_ready;
    assign credit_used = {1'b0, occ} + {2'b00, inflight_q};
    assign credit_lim  = 3'd2 + {2'b00, pop};
    assign rom_rd      = (state_q == RUN) && (credit_used < credit_lim);

    // k = (j mod (N >> (stage+1))) << stage
    assign mask     = LOG2N'((N >> (32'(stage_q) + 32'd1)) - 32'd1);
    assign rom_addr = ({1'b0, j_q} & mask) << stage_q;

    assign busy     = (state_q != IDLE);
    assign tw_valid = (occ != 2'd0);
    assign done     = (state_q == DRAIN) && pop && tw_last;

    // FSM, butterfly counter and the read-in-flight tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            stage_q         <= '0;
            j_q             <= '0;
            inflight_q      <= 1'b0;
            inflight_j_q    <= '0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= rom_rd;
            inflight_j_q    <= j_q;
            inflight_last_q <= (j_q == J_LAST);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        stage_q <= stage;
                        j_q     <= '0;
                    end
                end
                RUN: begin
                    if (rom_rd) begin
                        j_q <= j_q + JW'(1);
                        if (j_q == J_LAST) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    tw_skid_fifo #(
        .DW (DW),
        .IW (JW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_i        (inflight_q),
        .wr_data_i   (rom_data),
        .wr_idx_i    (inflight_j_q),
        .wr_last_i   (inflight_last_q),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_data_o (tw_data),
        .head_idx_o  (tw_idx),
        .head_last_o (tw_last)
    );

endmodule
